// File: rtl/data_memory_pipe.sv
// data_memory_pipe: pipelined RV32 data memory with valid/ready request/response, ROM ID window and response FIFO.
// Optional per-lane even parity when DMEM_PARITY_EN is defined.
module data_memory_pipe #(
  parameter int          DEPTH        = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter logic [31:0] ROM_BASE     = 32'h0010_0000,
  parameter logic [31:0] ROM_WORD0    = 32'd10338916,
  parameter logic [31:0] ROM_WORD1    = 32'd10452084,
  parameter int          READ_LATENCY = 1,
  parameter int          FIFO_DEPTH   = READ_LATENCY + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  reqSize,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspData,
  output logic        rspErr,
  output logic [1:0]  rspErrCode
`ifdef DMEM_PARITY_EN
  ,
  input  logic        parityFlip
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);
  localparam logic [31:0] BAD_LOAD = 32'hDEAD_BEEF;
  logic [31:0] mem [DEPTH];
  logic [31:0] ram_off, rom_off, wdata_sh, rd_q;
  logic        accept, mis, in_rom, in_ram, ram_ok;
  logic [1:0]  code_d;
  logic [3:0]  lanes;
  logic [AW-1:0] idx;
  assign accept   = reqValid && reqReady;
  assign ram_off  = reqAddr - BASE_ADDR;
  assign rom_off  = reqAddr - ROM_BASE;
  assign in_rom   = rom_off < 32'd8;
  assign in_ram   = ram_off < RAM_BYTES;
  assign mis      = (reqSize[1:0] == 2'b11) || (reqSize[2] && reqSize[1]) ||
                    (reqSize[1:0] == 2'b01 && reqAddr[0]) || (reqSize[1:0] == 2'b10 && reqAddr[1:0] != 2'b00);
  assign code_d   = mis ? 2'd1 : in_rom ? (reqWrite ? 2'd3 : 2'd0) : in_ram ? 2'd0 : 2'd2;
  assign ram_ok   = code_d == 2'd0 && !in_rom;
  assign lanes    = reqSize[1:0] == 2'b00 ? 4'b0001 << reqAddr[1:0] :
                    reqSize[1:0] == 2'b01 ? 4'b0011 << reqAddr[1:0] : 4'b1111;
  assign wdata_sh = reqWdata << {reqAddr[1:0], 3'b000};
  assign idx      = ram_off[AW+1:2];
`ifdef DMEM_PARITY_EN
  logic [3:0] par [DEPTH];
  logic [3:0] prd_q, lanes1_q;
`endif
  // Single port: an accepted store writes, an accepted load reads, never both.
  always_ff @(posedge clk) begin
    if (accept && reqWrite && ram_ok) begin
      for (int i = 0; i < 4; i++)
        if (lanes[i]) begin
          mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
`ifdef DMEM_PARITY_EN
          par[idx][i] <= ^wdata_sh[8*i +: 8] ^ parityFlip;
`endif
        end
    end else if (accept && !reqWrite && ram_ok) begin
      rd_q <= mem[idx];
`ifdef DMEM_PARITY_EN
      prd_q <= par[idx];
`endif
    end
  end
  logic        v1_q, wr1_q, rom1_q, romsel1_q;
  logic [1:0]  code1_q, off1_q;
  logic [2:0]  size1_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q      <= 1'b0;
      wr1_q     <= 1'b0;
      rom1_q    <= 1'b0;
      romsel1_q <= 1'b0;
      code1_q   <= 2'd0;
      off1_q    <= 2'd0;
      size1_q   <= 3'd0;
`ifdef DMEM_PARITY_EN
      lanes1_q  <= 4'd0;
`endif
    end else begin
      v1_q      <= accept;
      wr1_q     <= reqWrite;
      rom1_q    <= in_rom && !mis;
      romsel1_q <= rom_off[2];
      code1_q   <= code_d;
      off1_q    <= reqAddr[1:0];
      size1_q   <= reqSize;
`ifdef DMEM_PARITY_EN
      lanes1_q  <= lanes;
`endif
    end
  end
  logic [31:0] word, sh, ext, data1;
  logic [1:0]  code1;
  logic        perr;
  assign word  = rom1_q ? (romsel1_q ? ROM_WORD1 : ROM_WORD0) : rd_q;
  assign sh    = word >> {off1_q, 3'b000};
  assign ext   = size1_q[1:0] == 2'b00 ? {{24{~size1_q[2] & sh[7]}}, sh[7:0]} :
                 size1_q[1:0] == 2'b01 ? {{16{~size1_q[2] & sh[15]}}, sh[15:0]} : sh;
`ifdef DMEM_PARITY_EN
  assign perr  = !wr1_q && code1_q == 2'd0 && !rom1_q &&
                 |(lanes1_q & (prd_q ^ {^rd_q[31:24], ^rd_q[23:16], ^rd_q[15:8], ^rd_q[7:0]}));
`else
  assign perr  = 1'b0;
`endif
  assign code1 = perr ? 2'd1 : code1_q;
  assign data1 = wr1_q ? 32'd0 : code1 != 2'd0 ? BAD_LOAD : ext;
  logic        p_v;
  logic [1:0]  p_code;
  logic [31:0] p_data;
  if (READ_LATENCY == 2) begin : g_lat2
    logic        v2_q;
    logic [1:0]  code2_q;
    logic [31:0] data2_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v2_q    <= 1'b0;
        code2_q <= 2'd0;
        data2_q <= 32'd0;
      end else begin
        v2_q    <= v1_q;
        code2_q <= code1;
        data2_q <= data1;
      end
    end
    assign p_v    = v2_q;
    assign p_code = code2_q;
    assign p_data = data2_q;
  end else begin : g_lat1
    assign p_v    = v1_q;
    assign p_code = code1;
    assign p_data = data1;
  end
  // Pipeline output bypasses the FIFO only when it is empty and the consumer is ready.
  logic [33:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, out_q;
  logic          push, pop, fire;
  assign push = p_v && (cnt_q != '0 || !rspReady);
  assign pop  = cnt_q != '0 && rspReady;
  assign fire = rspValid && rspReady;
  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= {p_code, p_data};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      wp_q  <= push ? (wp_q == PW'(FIFO_DEPTH - 1) ? '0 : wp_q + 1'b1) : wp_q;
      rp_q  <= pop ? (rp_q == PW'(FIFO_DEPTH - 1) ? '0 : rp_q + 1'b1) : rp_q;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      out_q <= out_q + CW'(accept) - CW'(fire);
    end
  end
  assign reqReady = out_q < CW'(FIFO_DEPTH);
  assign rspValid = cnt_q != '0 || p_v;
  assign {rspErrCode, rspData} = cnt_q != '0 ? fifo_q[rp_q] : p_v ? {p_code, p_data} : 34'd0;
  assign rspErr = rspErrCode != 2'd0;
endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: directed self-checking bench for data_memory_pipe (default parameters, no parity).
module tb_data_memory_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqValid = 1'b0, reqReady, reqWrite = 1'b0;
  logic [2:0]  reqSize = 3'b010;
  logic [31:0] reqAddr = '0, reqWdata = '0;
  logic        rspValid, rspReady = 1'b1, rspErr;
  logic [31:0] rspData;
  logic [1:0]  rspErrCode;
  int errs = 0, checks = 0;
  data_memory_pipe dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqAddr(reqAddr), .reqWdata(reqWdata), .rspValid(rspValid),
    .rspReady(rspReady), .rspData(rspData), .rspErr(rspErr), .rspErrCode(rspErrCode)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic txn(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] d, output logic [1:0] c, output logic e, output int lat);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqAddr = a; reqWdata = wd; rspReady = 1'b1;
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 1;
    while (!rspValid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    d = rspData; c = rspErrCode; e = rspErr;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] d;
    logic [1:0]  c;
    logic        e;
    int          lat, n, stale;
    logic [31:0] q[$];
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rspValid, 0);
    check("rst_data", rspData, 0);
    check("rst_err", rspErr, 0);
    check("rst_code", rspErrCode, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("rst_ready", reqReady, 1);
    txn(1, 3'b010, 32'h8000_0004, 32'h1234_5678, d, c, e, lat);
    check("sw_code", c, 0);
    check("sw_data", d, 0);
    txn(0, 3'b010, 32'h8000_0004, 0, d, c, e, lat);
    check("lw_data", d, 32'h1234_5678);
    check("lw_code", c, 0);
    check("lw_lat", lat, 1);
    txn(1, 3'b000, 32'h8000_0010, 32'h0000_0000, d, c, e, lat);
    txn(1, 3'b000, 32'h8000_0011, 32'h0000_0080, d, c, e, lat);
    check("sb_code", c, 0);
    txn(0, 3'b000, 32'h8000_0011, 0, d, c, e, lat);
    check("lb_sext", d, 32'hFFFF_FF80);
    txn(0, 3'b100, 32'h8000_0011, 0, d, c, e, lat);
    check("lbu_zext", d, 32'h0000_0080);
    txn(0, 3'b001, 32'h8000_0010, 0, d, c, e, lat);
    check("lh_sext", d, 32'hFFFF_8000);
    txn(0, 3'b101, 32'h8000_0010, 0, d, c, e, lat);
    check("lhu_zext", d, 32'h0000_8000);
    txn(0, 3'b010, 32'h8000_0002, 0, d, c, e, lat);
    check("mis_code", c, 1);
    check("mis_err", e, 1);
    check("mis_data", d, 32'hDEAD_BEEF);
    txn(0, 3'b011, 32'h8000_0004, 0, d, c, e, lat);
    check("badsize_code", c, 1);
    txn(1, 3'b001, 32'h8000_0001, 32'hFFFF, d, c, e, lat);
    check("sh_mis_code", c, 1);
    check("sh_mis_data", d, 0);
    txn(0, 3'b010, 32'h0000_0000, 0, d, c, e, lat);
    check("oor_code", c, 2);
    check("oor_data", d, 32'hDEAD_BEEF);
    txn(1, 3'b010, 32'h0010_0000, 32'h5555_5555, d, c, e, lat);
    check("romwr_code", c, 3);
    check("romwr_data", d, 0);
    txn(0, 3'b010, 32'h0010_0000, 0, d, c, e, lat);
    check("rom0", d, 32'd10338916);
    check("rom0_code", c, 0);
    txn(0, 3'b010, 32'h0010_0004, 0, d, c, e, lat);
    check("rom1", d, 32'd10452084);
    txn(1, 3'b010, 32'h8000_0FFC, 32'hCAFE_F00D, d, c, e, lat);
    txn(0, 3'b010, 32'h8000_0FFC, 0, d, c, e, lat);
    check("top_data", d, 32'hCAFE_F00D);
    check("top_code", c, 0);
    txn(0, 3'b010, 32'h8000_1000, 0, d, c, e, lat);
    check("past_top_code", c, 2);
    txn(1, 3'b010, 32'h8000_0040, 32'h1111_1111, d, c, e, lat);
    txn(1, 3'b010, 32'h8000_0044, 32'h2222_2222, d, c, e, lat);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rspReady = 1'b0; reqValid = 1'b1; reqWrite = 1'b0; reqSize = 3'b010;
      reqAddr = 32'h8000_0040 + 32'(4 * n);
      if (reqReady) n++;
    end
    @(negedge clk);
    reqValid = 1'b0;
    check("bp_accepts", n, 2);
    check("bp_ready_low", reqReady, 0);
    check("bp_valid", rspValid, 1);
    check("bp_rsp0", rspData, 32'h1111_1111);
    rspReady = 1'b1;
    @(negedge clk);
    check("bp_ready_back", reqReady, 1);
    check("bp_rsp1", rspData, 32'h2222_2222);
    @(negedge clk);
    check("bp_drained", rspValid, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rspValid) q.push_back(rspData);
      reqValid = i < 2; reqWrite = i == 0; reqSize = 3'b010;
      reqAddr = 32'h8000_0050; reqWdata = 32'h5A5A_5A5A;
    end
    check("fwd_count", q.size(), 2);
    if (q.size() >= 2) begin
      check("fwd_store_rsp", q[0], 0);
      check("fwd_load_rsp", q[1], 32'h5A5A_5A5A);
    end
    @(negedge clk);
    rspReady = 1'b0; reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h8000_0004;
    @(negedge clk);
    reqAddr = 32'h8000_0040;
    @(negedge clk);
    reqValid = 1'b0;
    check("inflight_valid", rspValid, 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", rspValid, 0);
    check("midrst_ready", reqReady, 1);
    @(negedge clk);
    rst = 1'b1; rspReady = 1'b1;
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (rspValid) stale++;
    end
    check("no_stale", stale, 0);
    check("post_rst_ready", reqReady, 1);
    txn(0, 3'b010, 32'h8000_0004, 0, d, c, e, lat);
    check("post_rst_lw", d, 32'h1234_5678);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
- Parametrised successor of the core's single-cycle data memory. Adds a valid/ready request channel, in-order responses with configurable read latency, and a response FIFO that absorbs backpressure.
- Load sign/zero extension and store lane alignment are done internally from the RV32 funct3 size code.
- Sits between the core's MEM stage and word-organised SRAM. Keeps a small read-only ID window for board identification.

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- ROM_BASE, 32'h0010_0000: byte address of ROM word 0; ROM word 1 is at ROM_BASE+4.
- ROM_WORD0, 10338916: value of ROM word 0.
- ROM_WORD1, 10452084: value of ROM word 1.
- READ_LATENCY, 1: cycles from request acceptance to response availability; legal values 1 or 2.
- FIFO_DEPTH, READ_LATENCY+1: response credit count; minimum READ_LATENCY+1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  block can accept a request.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes illegal.
- reqAddr  in  32  byte address.
- reqWdata  in  32  store data, right-aligned.
- rspValid  out  1  response present.
- rspReady  in  1  consumer accepts the response.
- rspData  out  32  load result, extended; 0 for stores.
- rspErr  out  1  response carries an error.
- rspErrCode  out  2  00 ok, 01 misaligned/illegal size, 10 out of range, 11 write to ROM.

Behaviour:
- Handshakes:
  - A request is accepted when reqValid && reqReady.
  - A response is consumed when rspValid && rspReady.
  - Every accepted request, loads and stores alike, produces exactly one response, in acceptance order.
- Credit counter `outstanding` (0..FIFO_DEPTH):
  - Increments on accept and decrements on consume; unchanged when both happen in the same cycle.
  - reqReady = (outstanding < FIFO_DEPTH). It is purely registered state and has no combinational path from rspReady.
- Latency:
  - With rspReady held high, rspValid rises exactly READ_LATENCY cycles after the accept edge.
  - Sustained throughput is 1 request per cycle.
  - READ_LATENCY=2 inserts one register stage after the SRAM read.
- Pipeline and FIFO:
  - Pipeline results enter the response FIFO.
  - When the FIFO is empty and rspReady is high, the FIFO is bypassed with no extra cycle.
  - The FIFO can never overflow because of the credit rule.
- Decode priority:
  1. Illegal size, H at addr[0]=1, or W at addr[1:0]!=0 → code 01.
  2. Address in the ROM window: a load returns the ROM word; a store gives code 11.
  3. Address in [BASE_ADDR, BASE_ADDR+4*DEPTH) → normal access.
  4. Anything else → code 10.
- Error responses:
  - Any error leaves memory unchanged.
  - Load errors return rspData = 32'hDEAD_BEEF; store errors return 0.
- Stores:
  - Byte lanes: B → 4'b0001<<addr[1:0]; H → 4'b0011<<addr[1:0]; W → 4'b1111.
  - Data is shifted left by 8*addr[1:0].
  - The write commits on the accept edge.
- Loads:
  - The word is read and the selected lane is shifted down to bit 0.
  - B/H are sign-extended; BU/HU are zero-extended; W is passed unchanged.
- Ordering:
  - A load accepted the cycle after a store to the same word returns the stored data.
  - The memory array has a single port; one access per cycle.
- Reset (rst low, asynchronous):
  - outstanding=0, all pipeline valids=0, FIFO empty.
  - rspValid=0, rspData=0, rspErr=0, rspErrCode=0.
  - reqReady reads 1 once rst is released.
  - Memory contents are not reset.
  - Reset mid-operation drops all in-flight responses; a store already committed stays committed.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane and written with the lane.
  - On a load, a parity mismatch on any lane read sets rspErr=1 with code 01 and returns rspData=32'hDEAD_BEEF.
  - A test-only input port parityFlip (1 bit) inverts the stored parity of written lanes.
- Not defined: no parity storage, no parityFlip port, and no parity errors.

Test Plan:
- Reset, then SW 32'h1234_5678 @8000_0004; then LW @8000_0004 with rspReady=1 → store response (err 0); load rspData=32'h1234_5678 exactly READ_LATENCY cycles after accept.
- Sign/zero extension: SB 8'h80 @8000_0011; LB @8000_0011 → 32'hFFFF_FF80; LBU → 32'h0000_0080; LH @8000_0010 → 32'hFFFF_8000 if the other byte is 0.
- Errors:
  - LW @8000_0002 → err 01, 32'hDEAD_BEEF.
  - LW @0000_0000 → err 10.
  - SW @0010_0000 → err 11; then LW @0010_0000 → 10338916 (ROM unchanged).
- Backpressure: rspReady=0, issue back-to-back loads → exactly FIFO_DEPTH accepted, then reqReady=0. Raise rspReady → responses drain in order, and reqReady returns the cycle after the first consume.
- Boundary: LW @BASE_ADDR+4*DEPTH-4 is valid; LW @BASE_ADDR+4*DEPTH → err 10.
- Reset mid-operation: assert rst with 2 loads in flight → rspValid=0 immediately; after release, no stale responses appear and outstanding=0.
